// File: rtl/synaptic_accum_array.sv
// Multi-channel synaptic current accumulator with floor clamp and per-channel step delay line.
// Optional macro SYNAPTIC_LEAK_EN: window close halves each accumulator instead of clearing it.
module synaptic_accum_array #(
    parameter int unsigned  NUM_CH  = 4,
    parameter int unsigned  DELAY   = 2,
    parameter logic [31:0]  I_FLOOR = 32'hC1600000,
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 EN,
    input  logic                 IN_VALID,
    input  logic [CH_W-1:0]      IN_CH,
    input  logic [31:0]          SYNAPTIC_IN,
    output logic [32*NUM_CH-1:0] I,
    output logic                 I_VALID,
    output logic                 BUSY,
    output logic                 OVERRUN
);

    typedef enum logic [1:0] {StIdle, StFlush, StDone} state_e;

    // IEEE-754 single add, round-to-nearest-even, subnormals kept, inf/NaN propagated.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y;
        logic [26:0] mx, my, mask, m;
        logic [27:0] sum;
        logic [9:0]  ex, ey, d, sh;
        logic [4:0]  lz;
        logic [24:0] rnd;
        logic        stk, up;
        if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0))
            return 32'h7FC00000;
        if (a[30:23] == 8'hFF)
            return (b[30:23] == 8'hFF && a[31] != b[31]) ? 32'h7FC00000 : a;
        if (b[30:23] == 8'hFF)
            return b;
        if (b[30:0] > a[30:0]) begin
            x = b;
            y = a;
        end else begin
            x = a;
            y = b;
        end
        mx = {(x[30:23] != 8'h00), x[22:0], 3'b000};
        my = {(y[30:23] != 8'h00), y[22:0], 3'b000};
        ex = (x[30:23] == 8'h00) ? 10'd1 : {2'b00, x[30:23]};
        ey = (y[30:23] == 8'h00) ? 10'd1 : {2'b00, y[30:23]};
        d  = ex - ey;
        if (d >= 10'd27) begin
            stk = |my;
            my  = '0;
        end else begin
            mask = ~({27{1'b1}} << d[4:0]);
            stk  = |(my & mask);
            my   = my >> d[4:0];
        end
        my[0] = my[0] | stk;
        if (x[31] == y[31]) begin
            sum = {1'b0, mx} + {1'b0, my};
            if (sum[27]) begin
                m  = sum[27:1] | {26'd0, sum[0]};
                ex = ex + 10'd1;
            end else begin
                m = sum[26:0];
            end
        end else begin
            m = mx - my;
            if (m == 27'd0)
                return 32'h00000000;
            lz = 5'd0;
            for (int i = 0; i < 27; i++) begin
                if (m[i]) lz = 5'(26 - i);
            end
            // Stop normalising at the minimum exponent so tiny results stay subnormal.
            sh = ({5'd0, lz} < ex - 10'd1) ? {5'd0, lz} : ex - 10'd1;
            m  = m << sh;
            ex = ex - sh;
        end
        up  = m[2] & (m[1] | m[0] | m[3]);
        rnd = {1'b0, m[26:3]} + {24'd0, up};
        if (rnd[24]) begin
            rnd = rnd >> 1;
            ex  = ex + 10'd1;
        end
        if (ex >= 10'd255)
            return {x[31], 8'hFF, 23'd0};
        return {x[31], rnd[23] ? ex[7:0] : 8'h00, rnd[22:0]};
    endfunction

    // Strict a > b; false whenever either operand is NaN, and +0 == -0.
    function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
        if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0))
            return 1'b0;
        if (a[30:0] == 31'd0 && b[30:0] == 31'd0)
            return 1'b0;
        if (a[31] != b[31])
            return b[31];
        return a[31] ? (a[30:0] < b[30:0]) : (a[30:0] > b[30:0]);
    endfunction

`ifdef SYNAPTIC_LEAK_EN
    function automatic logic [31:0] fp_half(input logic [31:0] x);
        if (x[30:23] <= 8'h01)
            return {x[31], 31'd0};
        if (x[30:23] == 8'hFF)
            return x;
        return {x[31], x[30:23] - 8'd1, x[22:0]};
    endfunction
`endif

    state_e          state_q, state_d;
    logic [CH_W-1:0] cnt_q, cnt_d;
    logic [31:0]     acc_q  [NUM_CH];
    logic [31:0]     pend_q [NUM_CH];
    logic [31:0]     dly_q  [NUM_CH][DELAY];

    logic [NUM_CH-1:0] ch_sel;
    logic [31:0]       acc_sel, pend_sel, add_a, add_y, clamp_y, close_in;
    logic              close_win;

    assign BUSY      = (state_q != StIdle);
    assign close_win = EN && (state_q == StIdle);

    // One-hot channel decode; stays all-zero for IN_CH >= NUM_CH so the input is dropped.
    always_comb begin
        ch_sel   = '0;
        acc_sel  = '0;
        pend_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (IN_CH == CH_W'(c)) begin
                ch_sel[c] = 1'b1;
                acc_sel   = acc_q[c];
            end
            if (cnt_q == CH_W'(c)) pend_sel = pend_q[c];
        end
    end

`ifdef SYNAPTIC_LEAK_EN
    assign add_a    = close_win ? fp_half(acc_sel) : acc_sel;
    assign close_in = add_y;
`else
    assign add_a    = acc_sel;
    assign close_in = SYNAPTIC_IN;
`endif

    assign add_y   = fp_add(add_a, SYNAPTIC_IN);
    assign clamp_y = fp_gt(pend_sel, I_FLOOR) ? pend_sel : I_FLOOR;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            StIdle: begin
                if (EN) state_d = StFlush;
            end
            StFlush: begin
                if (cnt_q == CH_W'(NUM_CH - 1)) state_d = StDone;
                else                            cnt_d   = cnt_q + 1'b1;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc_q[c]  <= '0;
                pend_q[c] <= '0;
                for (int j = 0; j < DELAY; j++) dly_q[c][j] <= '0;
            end
            I       <= '0;
            I_VALID <= 1'b0;
            OVERRUN <= 1'b0;
        end else begin
            I_VALID <= (state_q == StDone);
            if (EN && state_q != StIdle) OVERRUN <= 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
                if (close_win) begin
                    pend_q[c] <= acc_q[c];
`ifdef SYNAPTIC_LEAK_EN
                    acc_q[c]  <= fp_half(acc_q[c]);
`else
                    acc_q[c]  <= '0;
`endif
                    // A same-cycle input opens the new window.
                    if (IN_VALID && ch_sel[c]) acc_q[c] <= close_in;
                end else if (IN_VALID && !EN && ch_sel[c]) begin
                    acc_q[c] <= add_y;
                end
                if (state_q == StFlush && cnt_q == CH_W'(c)) begin
                    dly_q[c][0] <= clamp_y;
                    for (int j = 1; j < DELAY; j++) dly_q[c][j] <= dly_q[c][j-1];
                end
                if (state_q == StDone) I[32*c +: 32] <= dly_q[c][DELAY-1];
            end
        end
    end

endmodule

// File: tb/tb_synaptic_accum_array.sv
// Directed bench for synaptic_accum_array (NUM_CH=4, DELAY=2); follows SYNAPTIC_LEAK_EN if set.
module tb_synaptic_accum_array;

    localparam int NUM_CH = 4;
    localparam int DELAY  = 2;
    localparam int CH_W   = 2;
`ifdef SYNAPTIC_LEAK_EN
    localparam bit LEAK = 1'b1;
`else
    localparam bit LEAK = 1'b0;
`endif

    localparam logic [31:0] F0    = 32'h00000000;
    localparam logic [31:0] F1    = 32'h3F800000;
    localparam logic [31:0] F1P5  = 32'h3FC00000;
    localparam logic [31:0] F2    = 32'h40000000;
    localparam logic [31:0] F2P5  = 32'h40200000;
    localparam logic [31:0] F3    = 32'h40400000;
    localparam logic [31:0] F5    = 32'h40A00000;
    localparam logic [31:0] F8    = 32'h41000000;
    localparam logic [31:0] FH    = 32'h3F000000;
    localparam logic [31:0] FMH   = 32'hBF000000;
    localparam logic [31:0] FM5   = 32'hC0A00000;
    localparam logic [31:0] FM10  = 32'hC1200000;
    localparam logic [31:0] FM14  = 32'hC1600000;
    localparam logic [31:0] FNAN  = 32'h7FC00000;

    logic                 clk = 1'b0;
    logic                 rst, en, in_valid;
    logic [CH_W-1:0]      in_ch;
    logic [31:0]          syn_in;
    logic [32*NUM_CH-1:0] i_out;
    logic                 i_valid, busy, overrun;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    synaptic_accum_array #(
        .NUM_CH (NUM_CH),
        .DELAY  (DELAY),
        .I_FLOOR(32'hC1600000)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .EN         (en),
        .IN_VALID   (in_valid),
        .IN_CH      (in_ch),
        .SYNAPTIC_IN(syn_in),
        .I          (i_out),
        .I_VALID    (i_valid),
        .BUSY       (busy),
        .OVERRUN    (overrun)
    );

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send(input logic [CH_W-1:0] ch, input logic [31:0] val);
        @(negedge clk);
        in_valid = 1'b1;
        in_ch    = ch;
        syn_in   = val;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Pulses EN (optionally with an input), then waits up to 20 cycles for I_VALID.
    // lat = cycles from the EN edge to the I_VALID edge (-1 on timeout).
    task automatic step(input logic with_in, input logic [CH_W-1:0] ch, input logic [31:0] val,
                        output int lat, output int busy_n);
        @(negedge clk);
        en       = 1'b1;
        in_valid = with_in;
        in_ch    = ch;
        syn_in   = val;
        @(negedge clk);
        en       = 1'b0;
        in_valid = 1'b0;
        lat      = -1;
        busy_n   = 0;
        for (int n = 1; n <= 20; n++) begin
            if (busy) busy_n++;
            @(negedge clk);
            if (i_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        checks++; if (i_out !== '0) begin failures++; $display("FAIL reset_I got=%h exp=0", i_out); end
        checks++; if (i_valid !== 1'b0) begin failures++; $display("FAIL reset_I_VALID got=%b exp=0", i_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_BUSY got=%b exp=0", busy); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_OVERRUN got=%b exp=0", overrun); end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int lat, bn;
        logic [127:0] exp_i;
        do_reset();
        send(2'd1, F3);
        send(2'd1, F2);
        step(1'b0, 2'd0, F0, lat, bn);
        checks++; if (lat !== 5) begin failures++; $display("FAIL basic_latency got=%0d exp=5", lat); end
        checks++; if (bn !== 5) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=5", bn); end
        checks++; if (i_out !== '0) begin failures++; $display("FAIL basic_step1_I got=%h exp=0", i_out); end
        @(negedge clk);
        checks++; if (i_valid !== 1'b0) begin failures++; $display("FAIL basic_pulse_len got=%b exp=0", i_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_end got=%b exp=0", busy); end
        step(1'b0, 2'd0, F0, lat, bn);
        exp_i = {F0, F0, F5, F0};
        checks++; if (i_out !== exp_i) begin failures++; $display("FAIL basic_step2_I got=%h exp=%h", i_out, exp_i); end
    endtask

    task automatic test_clamp;
        int lat, bn;
        logic [127:0] exp_i;
        do_reset();
        send(2'd0, FM10);
        send(2'd0, FM10);
        send(2'd1, FM10);
        send(2'd3, F1P5);
        send(2'd3, FMH);
        step(1'b0, 2'd0, F0, lat, bn);
        checks++; if (lat !== 5) begin failures++; $display("FAIL clamp_latency got=%0d exp=5", lat); end
        send(2'd0, FM14);
        send(2'd2, FNAN);
        step(1'b0, 2'd0, F0, lat, bn);
        exp_i = {F1, F0, FM10, FM14};
        checks++; if (i_out !== exp_i) begin failures++; $display("FAIL clamp_sum_I got=%h exp=%h", i_out, exp_i); end
        step(1'b0, 2'd0, F0, lat, bn);
        exp_i = {LEAK ? FH : F0, FM14, LEAK ? FM5 : F0, FM14};
        checks++; if (i_out !== exp_i) begin failures++; $display("FAIL clamp_exact_nan_I got=%h exp=%h", i_out, exp_i); end
    endtask

    task automatic test_en_input;
        int lat, bn;
        logic [127:0] exp_i;
        do_reset();
        send(2'd2, F1);
        step(1'b1, 2'd2, F1, lat, bn);
        send(2'd2, F1);
        step(1'b0, 2'd0, F0, lat, bn);
        exp_i = {F0, F1, F0, F0};
        checks++; if (i_out !== exp_i) begin failures++; $display("FAIL en_input_old_I got=%h exp=%h", i_out, exp_i); end
        step(1'b0, 2'd0, F0, lat, bn);
        exp_i = {F0, LEAK ? F2P5 : F2, F0, F0};
        checks++; if (i_out !== exp_i) begin failures++; $display("FAIL en_input_new_I got=%h exp=%h", i_out, exp_i); end
    endtask

    task automatic test_overrun;
        int lat, bn, pulses;
        logic [127:0] exp_i;
        do_reset();
        send(2'd0, F3);
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0; in_valid = 1'b1; in_ch = 2'd1; syn_in = F2;
        @(negedge clk);
        in_valid = 1'b0; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_set got=%b exp=1", overrun); end
        pulses = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (i_valid) pulses++;
        end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL overrun_pulses got=%0d exp=1", pulses); end
        step(1'b0, 2'd0, F0, lat, bn);
        checks++; if (lat !== 5) begin failures++; $display("FAIL overrun_next_latency got=%0d exp=5", lat); end
        exp_i = {F0, F0, F0, F3};
        checks++; if (i_out !== exp_i) begin failures++; $display("FAIL overrun_w1_I got=%h exp=%h", i_out, exp_i); end
        step(1'b0, 2'd0, F0, lat, bn);
        exp_i = {F0, F0, F2, LEAK ? F1P5 : F0};
        checks++; if (i_out !== exp_i) begin failures++; $display("FAIL overrun_w2_I got=%h exp=%h", i_out, exp_i); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky got=%b exp=1", overrun); end
    endtask

    task automatic test_reset_mid_flush;
        int lat, bn, pulses;
        logic [127:0] exp_i;
        do_reset();
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL midrst_overrun_clr got=%b exp=0", overrun); end
        send(2'd0, F3);
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (i_valid) pulses++;
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL midrst_pulses got=%0d exp=0", pulses); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++; if (i_out !== '0) begin failures++; $display("FAIL midrst_I got=%h exp=0", i_out); end
        send(2'd3, F3);
        step(1'b0, 2'd0, F0, lat, bn);
        checks++; if (lat !== 5) begin failures++; $display("FAIL midrst_latency got=%0d exp=5", lat); end
        checks++; if (i_out !== '0) begin failures++; $display("FAIL midrst_step1_I got=%h exp=0", i_out); end
        step(1'b0, 2'd0, F0, lat, bn);
        exp_i = {F3, F0, F0, F0};
        checks++; if (i_out !== exp_i) begin failures++; $display("FAIL midrst_step2_I got=%h exp=%h", i_out, exp_i); end
    endtask

`ifdef SYNAPTIC_LEAK_EN
    task automatic test_leak;
        int lat, bn;
        logic [127:0] exp_i;
        do_reset();
        send(2'd3, F8);
        step(1'b0, 2'd0, F0, lat, bn);
        send(2'd3, F1);
        step(1'b0, 2'd0, F0, lat, bn);
        exp_i = {F8, F0, F0, F0};
        checks++; if (i_out !== exp_i) begin failures++; $display("FAIL leak_w1_I got=%h exp=%h", i_out, exp_i); end
        step(1'b0, 2'd0, F0, lat, bn);
        exp_i = {F5, F0, F0, F0};
        checks++; if (i_out !== exp_i) begin failures++; $display("FAIL leak_w2_I got=%h exp=%h", i_out, exp_i); end
    endtask
`endif

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        in_valid = 1'b0;
        in_ch    = '0;
        syn_in   = '0;
        test_reset();
        test_basic();
        test_clamp();
        test_en_input();
        test_overrun();
        test_reset_mid_flush();
`ifdef SYNAPTIC_LEAK_EN
        test_leak();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
